// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an in-order byte FIFO. Frame format (data width,
// parity, stop bits) and the baud divisor are captured when a byte is popped,
// so a frame is never disturbed by configuration changes while it is on the wire.
module uart_tx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic [DIV_W-1:0]              div,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              push, pop;

    // Frame engine state
    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              stop_q, stop_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              par_en_q, par_en_d;
    logic              two_stop_q, two_stop_d;
    logic              load;
    logic              tx_c;
    logic              tx_q, busy_q;

    assign in_ready = (count_q < CW'(FIFO_DEPTH));
    assign push     = in_valid & in_ready;
    assign count    = count_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

    // FIFO data array; no reset needed since occupancy guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Frame engine next-state: bit sequencing, bit-period countdown and pop decision
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        shift_d    = shift_q;
        par_d      = par_q;
        div_d      = div_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        load       = 1'b0;
        pop        = 1'b0;
        tx_c       = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (count_q != '0) load = 1'b1;
            end
            StStart: begin
                tx_c = 1'b0;
                if (cnt_q == '0) begin
                    state_d = StData;
                    cnt_d   = div_q;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            StData: begin
                tx_c = shift_q[0];
                if (cnt_q == '0) begin
                    cnt_d = div_q;
                    if (bit_q == BW'(DATA_W - 1)) begin
                        state_d = par_en_q ? StParity : StStop;
                        stop_d  = 1'b0;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            StParity: begin
                tx_c = par_q;
                if (cnt_q == '0) begin
                    state_d = StStop;
                    stop_d  = 1'b0;
                    cnt_d   = div_q;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            StStop: begin
                tx_c = 1'b1;
                if (cnt_q == '0) begin
                    // stop_q counts completed stop bits; two_stop_q selects the last one
                    if (stop_q == two_stop_q) begin
                        if (count_q != '0) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        stop_d = 1'b1;
                        cnt_d  = div_q;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Pop: capture the head byte and freeze the frame configuration
        if (load) begin
            pop        = 1'b1;
            state_d    = StStart;
            cnt_d      = div;
            bit_d      = '0;
            stop_d     = 1'b0;
            shift_d    = mem[rd_ptr_q];
            par_d      = (^mem[rd_ptr_q]) ^ parity_odd;
            div_d      = div;
            par_en_d   = parity_en;
            two_stop_d = two_stop;
        end
    end

    // Frame engine registers; tx and busy are registered one cycle behind the state
    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_c;
            busy_q     <= (state_q != StIdle);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed scenarios plus random traffic, all
// outputs compared every cycle against a frame-level reference model.
module tb_uart_tx_fifo;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;

    bit                  clk = 1'b0;
    logic                res;
    logic [DIV_W-1:0]    div;
    logic                parity_en, parity_odd, two_stop;
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic                in_ready, tx, busy;
    logic [$clog2(FIFO_DEPTH):0] count;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk        (clk),
        .res        (res),
        .div        (div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .count      (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: queue of accepted bytes, plus the per-cycle line waveform
    // of frames already popped. A frame occupies the engine for m_left cycles.
    int unsigned m_q[$];
    bit          m_wave[$];
    int          m_left = 0;
    bit          m_tx   = 1'b1;
    bit          m_busy = 1'b0;

    task automatic model_step();
        bit do_pop, can_push;
        int unsigned d;
        int nbits, per;
        bit frame[$];
        if (res) begin
            m_q.delete();
            m_wave.delete();
            m_left = 0;
            m_tx   = 1'b1;
            m_busy = 1'b0;
            return;
        end
        m_tx     = (m_wave.size() > 0) ? m_wave.pop_front() : 1'b1;
        m_busy   = (m_left > 0);
        do_pop   = (m_q.size() > 0) && (m_left <= 1);
        can_push = in_valid && (m_q.size() < FIFO_DEPTH);
        if (do_pop) begin
            d = m_q.pop_front();
            frame.delete();
            frame.push_back(1'b0);
            for (int i = 0; i < DATA_W; i++) frame.push_back(d[i]);
            if (parity_en) frame.push_back(bit'($countones(d) % 2) ^ parity_odd);
            frame.push_back(1'b1);
            if (two_stop) frame.push_back(1'b1);
            nbits = frame.size();
            per   = int'(div) + 1;
            foreach (frame[i]) for (int k = 0; k < per; k++) m_wave.push_back(frame[i]);
            m_left = nbits * per;
        end else if (m_left > 0) begin
            m_left--;
        end
        if (can_push) m_q.push_back(int'(in_data));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        check("tx", int'(tx), int'(m_tx));
        check("busy", int'(busy), int'(m_busy));
        check("count", int'(count), m_q.size());
        check("in_ready", int'(in_ready), int'(m_q.size() < FIFO_DEPTH));
    end

    task automatic cfg(input int d, input bit pe, input bit po, input bit ts);
        div        = DIV_W'(d);
        parity_en  = pe;
        parity_odd = po;
        two_stop   = ts;
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (!(busy == 1'b0 && count == '0 && m_left == 0 && m_wave.size() == 0)
               && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (i >= budget) check("drain_timeout", 0, 1);
        tick(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        cfg(3, 0, 0, 0);
        tick(3);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(count), 0);
        check("rst_ready", int'(in_ready), 1);
        res = 1'b0;
        tick(2);

        // Basic frame: 0xA5, 4-cycle bits, 40-cycle frame
        cfg(3, 0, 0, 0);
        push(8'hA5);                 // now after edge E
        tick(2);                     // E+2
        check("basic_start", int'(tx), 0);
        check("basic_busy", int'(busy), 1);
        tick(4);                     // E+6: data bit0 = 1
        check("basic_bit0", int'(tx), 1);
        tick(4);                     // E+10: data bit1 = 0
        check("basic_bit1", int'(tx), 0);
        tick(31);                    // E+41: last stop cycle
        check("basic_stop", int'(tx), 1);
        check("basic_busy_end", int'(busy), 1);
        tick(1);                     // E+42
        check("basic_idle", int'(busy), 0);
        wait_drain(200);

        // Parity: 0x07 has three ones
        cfg(0, 1, 0, 0);
        push(8'h07);
        tick(11);
        check("par_even", int'(tx), 1);
        wait_drain(100);
        cfg(0, 1, 1, 0);
        push(8'h07);
        tick(11);
        check("par_odd", int'(tx), 0);
        wait_drain(100);
        cfg(0, 1, 1, 1);
        push(8'h07);
        tick(13);                    // second stop bit, last frame cycle
        check("two_stop_last", int'(busy), 1);
        tick(1);
        check("two_stop_len", int'(busy), 0);
        wait_drain(100);

        // Back-to-back frames with div=1
        cfg(1, 0, 0, 0);
        push(8'h55);                 // E
        push(8'hAA);                 // E+1
        tick(20);                    // E+21: last stop of first frame
        check("b2b_stop", int'(tx), 1);
        tick(1);                     // E+22: second start
        check("b2b_start", int'(tx), 0);
        check("b2b_busy", int'(busy), 1);
        wait_drain(200);

        // Full / backpressure: 20 consecutive pushes, 17 accepted
        cfg(100, 0, 0, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = DATA_W'($urandom);
            @(negedge clk);
            if (i == 16 || i == 19) begin
                check("full_count", int'(count), 16);
                check("full_ready", int'(in_ready), 0);
            end
        end
        in_valid = 1'b0;
        wait_drain(20000);

        // Configuration latch: change div/parity mid-frame
        cfg(3, 0, 0, 0);
        push(8'h3A);                 // E
        tick(10);                    // E+10
        cfg(7, 1, 0, 0);
        push(8'hC3);                 // E+11
        tick(30);                    // E+41: first frame still on its stop bit
        check("latch_old_stop", int'(tx), 1);
        tick(4);                     // E+45: second frame, 8-cycle start bit
        check("latch_new_div", int'(tx), 0);
        wait_drain(400);

        // Reset mid-frame with five bytes queued
        cfg(3, 0, 0, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = DATA_W'(8'h10 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        tick(4);
        check("pre_rst_count", int'(count), 5);
        res = 1'b1;
        tick(1);
        check("mid_rst_tx", int'(tx), 1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        res = 1'b0;
        tick(1);
        push(8'h3C);
        wait_drain(200);

        // Random traffic with live configuration churn
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cfg($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
            end
            in_valid = 1'($urandom);
            in_data  = DATA_W'($urandom);
            res      = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        res      = 1'b0;
        wait_drain(5000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
